// File: rtl/memory_access_pkg.sv
// Shared definitions for the M-stage memory access unit: access-size codes,
// FSM states and the default ack timeout.
package memory_access_pkg;

   localparam int unsigned TimeoutDefault = 255;

   typedef enum logic [2:0] {
      StrLb  = 3'b000,
      StrLh  = 3'b001,
      StrLw  = 3'b010,
      StrLbu = 3'b100,
      StrLhu = 3'b101
   } str_ctrl_e;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StBusy = 1'b1
   } state_e;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign- or
// zero-extends it according to the load size code.
module load_align
   import memory_access_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  str_ctrl_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;

   assign shifted = rdata_i >> {offset_i, 3'b000};

   always_comb begin
      data_o = rdata_i;
      case (str_ctrl_i)
         StrLb:   data_o = {{24{shifted[7]}}, shifted[7:0]};
         StrLbu:  data_o = {24'b0, shifted[7:0]};
         StrLh:   data_o = {{16{shifted[15]}}, shifted[15:0]};
         StrLhu:  data_o = {16'b0, shifted[15:0]};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// M-stage data memory access: issues bus requests, stalls the pipeline until
// ack or timeout, and produces the W-stage register set with exception flags.
module memory_access
   import memory_access_pkg::*;
#(
   parameter int unsigned TIMEOUT = TimeoutDefault
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  strCtrlM,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic        MemtoRegM,
   input  logic [4:0]  rdM,
   input  logic [31:0] ALUoutM,
   input  logic [31:0] r2M,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stallM,
   output logic        RegWriteW,
   output logic        MemtoRegW,
   output logic [4:0]  rdW,
   output logic [31:0] ALUoutW,
   output logic [31:0] ReadDataW,
   output logic        misalignW,
   output logic        buserrW
);

   localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

   state_e      state_q;
   logic [15:0] cnt_q;
   logic        req_q, we_q;
   logic [3:0]  be_q;
   logic [31:0] addr_q, wdata_q;
   logic [1:0]  off_q;
   logic [2:0]  str_q;
   logic        reg_write_w_q, mem_to_reg_w_q, misalign_w_q, buserr_w_q;
   logic [4:0]  rd_w_q;
   logic [31:0] alu_out_w_q, read_data_w_q;

   logic        access, size_bad, misalign, go, timeout, done;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc, load_data;

   always_comb begin
      be_calc    = 4'b0000;
      wdata_calc = 32'b0;
      size_bad   = 1'b1;
      case (strCtrlM)
         StrLb, StrLbu: begin
            be_calc    = 4'b0001 << ALUoutM[1:0];
            wdata_calc = {4{r2M[7:0]}};
            size_bad   = 1'b0;
         end
         StrLh, StrLhu: begin
            be_calc    = 4'b0011 << ALUoutM[1:0];
            wdata_calc = {2{r2M[15:0]}};
            size_bad   = ALUoutM[0];
         end
         StrLw: begin
            be_calc    = 4'b1111;
            wdata_calc = r2M;
            size_bad   = |ALUoutM[1:0];
         end
         default: size_bad = 1'b1;
      endcase
   end

   assign access   = MemWriteM | MemtoRegM;
   assign misalign = access & size_bad;
   assign go       = access & ~size_bad;
   assign timeout  = (cnt_q == TimeoutCnt);
   assign done     = dmem_ack | timeout;
   // Gated by rst so every output reads 0 while reset is held.
   assign stallM   = ~rst & ((state_q == StIdle) ? go : ~done);

   load_align u_load_align (
      .rdata_i    (dmem_rdata),
      .offset_i   (off_q),
      .str_ctrl_i (str_q),
      .data_o     (load_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         cnt_q          <= 16'd0;
         req_q          <= 1'b0;
         we_q           <= 1'b0;
         be_q           <= 4'b0;
         addr_q         <= 32'b0;
         wdata_q        <= 32'b0;
         off_q          <= 2'b0;
         str_q          <= 3'b0;
         reg_write_w_q  <= 1'b0;
         mem_to_reg_w_q <= 1'b0;
         rd_w_q         <= 5'b0;
         alu_out_w_q    <= 32'b0;
         read_data_w_q  <= 32'b0;
         misalign_w_q   <= 1'b0;
         buserr_w_q     <= 1'b0;
      end else begin
         // W defaults to a bubble; completing cases override below.
         reg_write_w_q  <= 1'b0;
         mem_to_reg_w_q <= 1'b0;
         rd_w_q         <= 5'b0;
         alu_out_w_q    <= 32'b0;
         read_data_w_q  <= 32'b0;
         misalign_w_q   <= 1'b0;
         buserr_w_q     <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (go) begin
                  state_q <= StBusy;
                  cnt_q   <= 16'd0;
                  req_q   <= 1'b1;
                  we_q    <= MemWriteM;
                  be_q    <= be_calc;
                  addr_q  <= {ALUoutM[31:2], 2'b00};
                  wdata_q <= wdata_calc;
                  off_q   <= ALUoutM[1:0];
                  str_q   <= strCtrlM;
               end else begin
                  reg_write_w_q  <= RegWriteM & ~misalign;
                  mem_to_reg_w_q <= MemtoRegM;
                  rd_w_q         <= rdM;
                  alu_out_w_q    <= ALUoutM;
                  misalign_w_q   <= misalign;
               end
            end
            StBusy: begin
               if (dmem_ack) begin
                  reg_write_w_q  <= RegWriteM;
                  mem_to_reg_w_q <= MemtoRegM;
                  rd_w_q         <= rdM;
                  alu_out_w_q    <= ALUoutM;
                  read_data_w_q  <= load_data;
               end else if (timeout) begin
                  buserr_w_q <= 1'b1;
               end
               if (done) begin
                  state_q <= StIdle;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  be_q    <= 4'b0;
                  addr_q  <= 32'b0;
                  wdata_q <= 32'b0;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_be    = be_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign RegWriteW  = reg_write_w_q;
   assign MemtoRegW  = mem_to_reg_w_q;
   assign rdW        = rd_w_q;
   assign ALUoutW    = alu_out_w_q;
   assign ReadDataW  = read_data_w_q;
   assign misalignW  = misalign_w_q;
   assign buserrW    = buserr_w_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed and randomized transactions against memory_access, checked by a
// size/alignment/extension reference model computed with plain arithmetic.
module tb_memory_access;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  strCtrlM;
   logic        RegWriteM, MemWriteM, MemtoRegM;
   logic [4:0]  rdM;
   logic [31:0] ALUoutM, r2M;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic        stallM, RegWriteW, MemtoRegW, misalignW, buserrW;
   logic [4:0]  rdW;
   logic [31:0] ALUoutW, ReadDataW;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   memory_access #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .strCtrlM   (strCtrlM),
      .RegWriteM  (RegWriteM),
      .MemWriteM  (MemWriteM),
      .MemtoRegM  (MemtoRegM),
      .rdM        (rdM),
      .ALUoutM    (ALUoutM),
      .r2M        (r2M),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_be    (dmem_be),
      .dmem_rdata (dmem_rdata),
      .dmem_ack   (dmem_ack),
      .stallM     (stallM),
      .RegWriteW  (RegWriteW),
      .MemtoRegW  (MemtoRegW),
      .rdW        (rdW),
      .ALUoutW    (ALUoutW),
      .ReadDataW  (ReadDataW),
      .misalignW  (misalignW),
      .buserrW    (buserrW)
   );

   task automatic check(input string tag, input string fld, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s.%s: observed 0x%08h expected 0x%08h", tag, fld, got, exp);
      end
   endtask

   // Reference model: sizes from the access code, lanes from address mod 4.
   function automatic int unsigned size_of(input logic [2:0] s);
      case (s)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   function automatic bit is_mis(input bit acc, input logic [2:0] s, input logic [31:0] a);
      int unsigned sz = size_of(s);
      if (!acc) return 1'b0;
      if (sz == 0) return 1'b1;
      return (a % sz) != 0;
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] s, input logic [31:0] a);
      int unsigned sz = size_of(s);
      int unsigned lanes = (1 << sz) - 1;
      return 4'((lanes << (a % 4)) & 15);
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] s, input logic [31:0] r);
      case (size_of(s))
         1:       return (r % 256) * 32'h0101_0101;
         2:       return (r % 65536) * 32'h0001_0001;
         default: return r;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] s, input logic [31:0] a,
                                            input logic [31:0] rd);
      logic [31:0] v;
      int unsigned sz = size_of(s);
      bit sgn = (s == 3'b000) || (s == 3'b001);
      if (sz == 1) begin
         v = (rd >> (8 * (a % 4))) % 256;
         if (sgn && v >= 128) v = v - 256;
      end else if (sz == 2) begin
         v = (rd >> (8 * (a % 4))) % 65536;
         if (sgn && v >= 32768) v = v - 65536;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   task automatic xact(input string tag, input bit mw, input bit mr, input bit rw,
                       input logic [2:0] s, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] r2, input logic [31:0] rdat,
                       input int unsigned ack_at, input bit idle_ack);
      bit acc = mw | mr;
      bit mis = is_mis(acc, s, a);
      bit go = acc && !mis;
      bit timed_out = ack_at > TO;
      int unsigned done_at = timed_out ? TO : ack_at;
      int unsigned stalls = 0;
      bit fin = 1'b0;
      @(negedge clk);
      MemWriteM = mw; MemtoRegM = mr; RegWriteM = rw; strCtrlM = s; rdM = rd;
      ALUoutM = a; r2M = r2; dmem_rdata = rdat; dmem_ack = idle_ack;
      #1;
      check(tag, "stall_idle", 32'(stallM), 32'(go));
      check(tag, "req_idle", 32'(dmem_req), 32'd0);
      if (stallM) stalls++;
      @(posedge clk); #1;
      if (!go) begin
         check(tag, "RegWriteW", 32'(RegWriteW), 32'(rw && !mis));
         check(tag, "misalignW", 32'(misalignW), 32'(mis));
         check(tag, "ALUoutW", ALUoutW, a);
         check(tag, "rdW", 32'(rdW), 32'(rd));
         check(tag, "buserrW", 32'(buserrW), 32'd0);
         check(tag, "req_after", 32'(dmem_req), 32'd0);
      end else begin
         for (int b = 0; b <= int'(TO) + 1 && !fin; b++) begin
            @(negedge clk);
            dmem_ack = (b == int'(ack_at));
            #1;
            check(tag, "req", 32'(dmem_req), 32'd1);
            check(tag, "addr", dmem_addr, a - (a % 4));
            check(tag, "be", 32'(dmem_be), 32'(exp_be(s, a)));
            check(tag, "we", 32'(dmem_we), 32'(mw));
            if (mw) check(tag, "wdata", dmem_wdata, exp_wdata(s, r2));
            check(tag, "stall_busy", 32'(stallM), 32'(b != int'(done_at)));
            if (stallM) stalls++;
            @(posedge clk); #1;
            if (b == int'(done_at)) begin
               fin = 1'b1;
               check(tag, "buserrW", 32'(buserrW), 32'(timed_out));
               check(tag, "misalignW", 32'(misalignW), 32'd0);
               check(tag, "RegWriteW", 32'(RegWriteW), 32'(rw && !timed_out));
               check(tag, "MemtoRegW", 32'(MemtoRegW), 32'(mr && !timed_out));
               if (!timed_out) begin
                  check(tag, "ALUoutW", ALUoutW, a);
                  check(tag, "rdW", 32'(rdW), 32'(rd));
                  if (mr) check(tag, "ReadDataW", ReadDataW, exp_load(s, a, rdat));
               end
               check(tag, "req_done", 32'(dmem_req), 32'd0);
            end else begin
               check(tag, "bubble", 32'(RegWriteW), 32'd0);
            end
         end
         check(tag, "stall_cycles", stalls, 1 + done_at);
      end
   endtask

   initial begin
      rst = 1'b1;
      strCtrlM = 3'b0; RegWriteM = 1'b0; MemWriteM = 1'b0; MemtoRegM = 1'b0;
      rdM = 5'd0; ALUoutM = 32'd0; r2M = 32'd0; dmem_rdata = 32'd0; dmem_ack = 1'b0;
      #1;
      check("reset", "req", 32'(dmem_req), 32'd0);
      check("reset", "be", 32'(dmem_be), 32'd0);
      check("reset", "addr", dmem_addr, 32'd0);
      check("reset", "wdata", dmem_wdata, 32'd0);
      check("reset", "RegWriteW", 32'(RegWriteW), 32'd0);
      check("reset", "stall", 32'(stallM), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      xact("nonacc", 0, 0, 1, 3'b010, 5'd3, 32'h1234, 32'h0, 32'h0, 0, 0);
      xact("sb", 1, 0, 0, 3'b000, 5'd0, 32'h103, 32'hAB, 32'h0, 3, 0);
      check("sb", "be_const", 32'(exp_be(3'b000, 32'h103)), 32'h8);
      xact("lb", 0, 1, 1, 3'b000, 5'd5, 32'h101, 32'h0, 32'h0000_8000, 1, 0);
      xact("lbu", 0, 1, 1, 3'b100, 5'd5, 32'h101, 32'h0, 32'h0000_8000, 1, 1);
      xact("lw_mis", 0, 1, 1, 3'b010, 5'd6, 32'h102, 32'h0, 32'h0, 0, 0);
      xact("timeout", 0, 1, 1, 3'b010, 5'd7, 32'h200, 32'h0, 32'hDEAD_BEEF, 99, 0);

      // Reset in the middle of a BUSY access, then a stray ack.
      @(negedge clk);
      MemtoRegM = 1'b1; RegWriteM = 1'b1; strCtrlM = 3'b010; ALUoutM = 32'h300;
      dmem_ack = 1'b0;
      @(posedge clk);
      @(negedge clk); #1;
      check("rst_busy", "req_before", 32'(dmem_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_busy", "req", 32'(dmem_req), 32'd0);
      check("rst_busy", "addr", dmem_addr, 32'd0);
      check("rst_busy", "stall", 32'(stallM), 32'd0);
      check("rst_busy", "RegWriteW", 32'(RegWriteW), 32'd0);
      MemtoRegM = 1'b0; RegWriteM = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      dmem_ack = 1'b1;
      dmem_rdata = 32'h1111_2222;
      @(posedge clk); #1;
      check("rst_busy", "late_ack_wr", 32'(RegWriteW), 32'd0);
      check("rst_busy", "late_ack_req", 32'(dmem_req), 32'd0);
      check("rst_busy", "late_ack_stall", 32'(stallM), 32'd0);

      for (int i = 0; i < 60; i++) begin
         int unsigned kind = $urandom_range(0, 2);
         logic [31:0] a = $urandom;
         xact("rand", kind == 2, kind == 1, 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), a, $urandom, $urandom,
              $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      end

      @(negedge clk);
      MemWriteM = 1'b0; MemtoRegM = 1'b0; RegWriteM = 1'b0; dmem_ack = 1'b0;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles a request may wait for dmem_ack before an error is flagged.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 strCtrlM  input  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; all other codes are illegal.
REQ-005 RegWriteM, MemWriteM, MemtoRegM  input  1 each  M-stage controls.
REQ-006 rdM  input  5  destination register.
REQ-007 ALUoutM  input  32  effective address, or ALU result when there is no memory access.
REQ-008 r2M  input  32  store data.
REQ-009 dmem_req, dmem_we  output  1 each  bus request and write-enable.
REQ-010 dmem_addr  output  32  word-aligned address ({ALUoutM[31:2],2'b00}).
REQ-011 dmem_wdata  output  32  lane-shifted store data.
REQ-012 dmem_be  output  4  byte enables.
REQ-013 dmem_rdata  input  32  read word.
REQ-014 dmem_ack  input  1  one-cycle completion pulse.
REQ-015 stallM  output  1  freezes the E/M register and upstream while high.
REQ-016 RegWriteW, MemtoRegW  output  1 each  W-stage controls.
REQ-017 rdW  output  5  W-stage destination register.
REQ-018 ALUoutW, ReadDataW  output  32 each  W-stage ALU result and load data.
REQ-019 misalignW, buserrW  output  1 each  exception flags, aligned with the W instruction.

Function
REQ-020 An access exists when MemWriteM|MemtoRegM; a non-access passes to the W registers in 1 cycle with stallM=0.
REQ-021 Misalignment is defined as: halfword with ALUoutM[0]=1, word with ALUoutM[1:0]!=0, or an illegal strCtrlM code on an access.
REQ-022 A misaligned access issues no bus request, passes to W in 1 cycle with misalignW=1 and RegWriteW=0, and stores nothing.
REQ-023 FSM states: IDLE, BUSY.
  - IDLE -> BUSY on an aligned access.
  - BUSY -> IDLE on dmem_ack or on timeout.
REQ-024 stallM is combinational: it equals 1 in IDLE when an aligned access is present, and in BUSY until the ack/timeout cycle; it is 0 on the ack/timeout cycle.
REQ-025 In BUSY: dmem_req=1, and dmem_addr, dmem_we, dmem_be, dmem_wdata are registered at BUSY entry and held constant until ack.
REQ-026 Byte enables:
  - byte access: 4'b0001<<addr[1:0].
  - half access: 4'b0011<<addr[1:0].
  - word access: 4'b1111.
  - loads drive the same dmem_be values as stores.
REQ-027 Store data is replicated across lanes: byte {4{r2M[7:0]}}, half {2{r2M[15:0]}}, word r2M.
REQ-028 Load extraction: select the lane using addr[1:0], then sign-extend (lb/lh) or zero-extend (lbu/lhu); lw passes the word unchanged.
REQ-029 On the dmem_ack cycle in BUSY, W registers load the M controls, ALUoutM, and the extracted data; the FSM returns to IDLE.
REQ-030 While stalled (before ack), W registers load a bubble: RegWriteW=0, MemtoRegW=0, flags 0.
REQ-031 A 16-bit wait counter clears on BUSY entry and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT, the access completes as a bubble with buserrW=1 and RegWriteW=0.
  - The FSM returns to IDLE.
REQ-032 dmem_ack in IDLE is ignored.
REQ-033 A back-to-back access can enter BUSY on the cycle after IDLE; there is no extra idle cycle beyond the stall semantics.

Reset
REQ-034 rst forces state IDLE, counter 0, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, and all W outputs and flags to 0, immediately and asynchronously.
REQ-035 rst asserted mid-BUSY abandons the access; a later ack is ignored per REQ-032.

Structure
REQ-036 strCtrl encodings, FSM state encoding and the TIMEOUT default belong in the shared core package/include.
REQ-037 Load lane extraction with sign/zero extension is one sub-module, load_align; everything else stays in memory_access.

Verification
REQ-038 Non-access: RegWriteM=1, ALUoutM=0x1234 -> next cycle ALUoutW=0x1234, RegWriteW=1, stallM never high.
REQ-039 sb: addr 0x103, r2M=0xAB, ack after 3 cycles -> dmem_be=1000, dmem_wdata=0xABABABAB, dmem_addr=0x100, stallM high 4 cycles.
REQ-040 lb: addr 0x101, dmem_rdata=0x0000_8000 -> ReadDataW=0xFFFFFF80; same access with lbu -> 0x00000080.
REQ-041 lw: addr 0x102 -> no dmem_req, misalignW=1, RegWriteW=0 after 1 cycle.
REQ-042 TIMEOUT=4, no ack -> buserrW=1 after 5 cycles; stallM falls; dmem_req deasserts.
REQ-043 rst pulse during BUSY -> all outputs 0 immediately; an ack arriving afterwards produces no W write.
